// File: rtl/aes_sbox_mask_prng_if.sv
// Purpose : seed-load handshake and randomness bus between the mask PRNG and its neighbours.
// Latency : n/a (wiring only).
// Backpressure: seed words move on SeedValidxSI & SeedReadyxSO; the randomness bus has no backpressure.
// Ports   : master = host/TRNG + S-box side, slave = the PRNG itself.
interface aes_sbox_mask_prng_if #(
  parameter int Z_WIDTH = 18,
  parameter int B_WIDTH = 8
);
  logic               ReseedxSI;
  logic [31:0]        SeedxDI;
  logic               SeedValidxSI;
  logic               SeedReadyxSO;
  logic               EnablexSI;
  logic [Z_WIDTH-1:0] RandomZ;
  logic [B_WIDTH-1:0] RandomB;
  logic               RndValidxSO;

  modport master (
    output ReseedxSI, SeedxDI, SeedValidxSI, EnablexSI,
    input  SeedReadyxSO, RandomZ, RandomB, RndValidxSO
  );

  modport slave (
    input  ReseedxSI, SeedxDI, SeedValidxSI, EnablexSI,
    output SeedReadyxSO, RandomZ, RandomB, RndValidxSO
  );
endinterface

// File: rtl/aes_sbox_mask_prng.sv
// Purpose : fresh-mask generator for the masked AES S-box; one 31-bit LFSR lane per random bit.
// Latency : RandomZ/RandomB are the lane MSBs directly (0 cycles from lane state); lanes step on the enabling edge.
// Backpressure: seed input ready only in LOAD; the output bus is consumed the cycle it is presented.
// Ports   : ClkxCI clock, RstxBI async active-low reset, bus = seed handshake, reseed,
//           enable, RandomZ/RandomB randomness, RndValidxSO (high in RUN).
module aes_sbox_mask_prng #(
  parameter int SHARES        = 2,
  parameter int Z_WIDTH       = 18,
  parameter int B_WIDTH       = 8,
  parameter int WARMUP_CYCLES = 64
) (
  input  logic                ClkxCI,
  input  logic                RstxBI,
  aes_sbox_mask_prng_if.slave bus
);

  localparam int L    = Z_WIDTH + B_WIDTH;
  localparam int WC_W = $clog2(L + 1);
  localparam int WU_W = (WARMUP_CYCLES > 0) ? $clog2(WARMUP_CYCLES + 1) : 1;

  localparam logic [WC_W-1:0] LAST_WORD = WC_W'(L - 1);
  localparam logic [WC_W-1:0] WORD_END  = WC_W'(L);
  // Value of the warm-up counter during the final warm-up step.
  localparam logic [WU_W-1:0] WU_LAST   = WU_W'((WARMUP_CYCLES > 0) ? WARMUP_CYCLES - 1 : 0);

  // Elaboration-time sanity checks on the integration parameters.
  if (SHARES < 1) begin : g_bad_shares
    $error("aes_sbox_mask_prng: SHARES must be at least 1");
  end
  if (WARMUP_CYCLES < 0) begin : g_bad_warmup
    $error("aes_sbox_mask_prng: WARMUP_CYCLES must not be negative");
  end
  if ($bits(bus.RandomZ) != Z_WIDTH || $bits(bus.RandomB) != B_WIDTH) begin : g_bad_if
    $error("aes_sbox_mask_prng: interface widths disagree with Z_WIDTH/B_WIDTH");
  end

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [WC_W-1:0] word_cnt_q, word_cnt_d;
  logic [WU_W-1:0] wu_cnt_q, wu_cnt_d;
  logic            step;
  logic            seed_wr;
  logic [30:0]     seed_word;
  logic [L-1:0]    lane_msb;

  // Bit 31 of the seed word carries no entropy we use.
  logic unused_seed_msb;
  assign unused_seed_msb = bus.SeedxDI[31];

  // An all-zero seed would lock the LFSR at zero forever.
  assign seed_word = (bus.SeedxDI[30:0] == 31'h0) ? 31'h1 : bus.SeedxDI[30:0];

  // ---------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) begin
      state_q    <= ST_LOAD;
      word_cnt_q <= '0;
      wu_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      wu_cnt_q   <= wu_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    wu_cnt_d   = wu_cnt_q;
    seed_wr    = 1'b0;
    step       = 1'b0;

    if (bus.ReseedxSI) begin
      // Reseed overrides everything: no lane write, no step this cycle.
      state_d    = ST_LOAD;
      word_cnt_d = '0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (bus.SeedValidxSI) begin
            seed_wr = 1'b1;
            if (word_cnt_q != WORD_END) begin
              word_cnt_d = word_cnt_q + 1'b1;
            end
            if (word_cnt_q == LAST_WORD) begin
              wu_cnt_d = '0;
              state_d  = (WARMUP_CYCLES == 0) ? ST_RUN : ST_WARMUP;
            end
          end
        end
        ST_WARMUP: begin
          step = 1'b1;
          if (wu_cnt_q == WU_LAST) begin
            state_d = ST_RUN;
          end else begin
            wu_cnt_d = wu_cnt_q + 1'b1;
          end
        end
        ST_RUN: begin
          step = bus.EnablexSI;
        end
        default: begin
          state_d = ST_LOAD;
        end
      endcase
    end
  end

  assign bus.SeedReadyxSO = (state_q == ST_LOAD);
  assign bus.RndValidxSO  = (state_q == ST_RUN);

  // ---------------------------------------------------------------------
  // LFSR lanes, x^31 + x^28 + 1, shifting towards the MSB
  // ---------------------------------------------------------------------
  for (genvar k = 0; k < L; k++) begin : g_lane
    localparam logic [WC_W-1:0] IDX = WC_W'(k);
    logic [30:0] lane_q;

    always_ff @(posedge ClkxCI or negedge RstxBI) begin
      if (!RstxBI) begin
        lane_q <= 31'h1;
      end else if (step) begin
        lane_q <= {lane_q[29:0], lane_q[30] ^ lane_q[27]};
      end else if (seed_wr && (word_cnt_q == IDX)) begin
        lane_q <= seed_word;
      end
    end

    assign lane_msb[k] = lane_q[30];
  end

  // Lanes 0..Z_WIDTH-1 feed RandomZ, the rest feed RandomB.
  assign bus.RandomZ = lane_msb[Z_WIDTH-1:0];
  assign bus.RandomB = lane_msb[L-1:Z_WIDTH];

endmodule

// File: tb/tb_aes_sbox_mask_prng.sv
module tb_aes_sbox_mask_prng;

  localparam int ZW = 18;
  localparam int BW = 8;
  localparam int NL = ZW + BW;

  logic clk;
  logic rst_n;

  aes_sbox_mask_prng_if #(.Z_WIDTH(ZW), .B_WIDTH(BW)) ia ();
  aes_sbox_mask_prng_if #(.Z_WIDTH(ZW), .B_WIDTH(BW)) ib ();

  aes_sbox_mask_prng #(.SHARES(2), .Z_WIDTH(ZW), .B_WIDTH(BW), .WARMUP_CYCLES(0)) dut_a (
    .ClkxCI(clk), .RstxBI(rst_n), .bus(ia)
  );
  aes_sbox_mask_prng #(.SHARES(2), .Z_WIDTH(ZW), .B_WIDTH(BW), .WARMUP_CYCLES(64)) dut_b (
    .ClkxCI(clk), .RstxBI(rst_n), .bus(ib)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        rs;
    logic        vld;
    logic [31:0] seed;
    logic        en;
    logic        rdy;
    logic        val;
    logic [17:0] z;
    logic [7:0]  b;
  } vec_t;

  vec_t va[$];

  logic [30:0] ma[NL];
  logic [30:0] mb[NL];
  logic [31:0] seeds_a[NL];
  logic [31:0] seeds_b[NL];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [30:0] lstep(input logic [30:0] s);
    return {s[29:0], s[30] ^ s[27]};
  endfunction

  function automatic logic [30:0] seed_of(input logic [31:0] w);
    return (w[30:0] == 31'h0) ? 31'h1 : w[30:0];
  endfunction

  function automatic vec_t mk(input logic rs, input logic vld, input logic [31:0] seed, input logic en,
                              input logic rdy, input logic val, input logic [17:0] z, input logic [7:0] b);
    vec_t v;
    v.rs = rs; v.vld = vld; v.seed = seed; v.en = en;
    v.rdy = rdy; v.val = val; v.z = z; v.b = b;
    return v;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    ia.ReseedxSI = 1'b0; ia.SeedValidxSI = 1'b0; ia.SeedxDI = 32'h0; ia.EnablexSI = 1'b0;
  endtask

  task automatic idle_b();
    ib.ReseedxSI = 1'b0; ib.SeedValidxSI = 1'b0; ib.SeedxDI = 32'h0; ib.EnablexSI = 1'b0;
  endtask

  task automatic chk_model_a(input string nm);
    logic [17:0] ez;
    logic [7:0]  eb;
    for (int k = 0; k < ZW; k++) ez[k] = ma[k][30];
    for (int j = 0; j < BW; j++) eb[j] = ma[ZW + j][30];
    chk({nm, "_z"}, 32'(ia.RandomZ), 32'(ez));
    chk({nm, "_b"}, 32'(ia.RandomB), 32'(eb));
  endtask

  task automatic chk_model_b(input string nm);
    logic [17:0] ez;
    logic [7:0]  eb;
    for (int k = 0; k < ZW; k++) ez[k] = mb[k][30];
    for (int j = 0; j < BW; j++) eb[j] = mb[ZW + j][30];
    chk({nm, "_z"}, 32'(ib.RandomZ), 32'(ez));
    chk({nm, "_b"}, 32'(ib.RandomB), 32'(eb));
  endtask

  task automatic load_b();
    for (int k = 0; k < NL; k++) begin
      ib.SeedValidxSI = 1'b1;
      ib.SeedxDI      = seeds_b[k];
      cyc();
      mb[k] = seed_of(seeds_b[k]);
    end
    idle_b();
  endtask

  initial begin
    rst_n = 1'b0;
    idle_a();
    idle_b();

    // ---------------- reset state ----------------
    #13;
    chk("rst_rdy_a", 32'(ia.SeedReadyxSO), 32'd1);
    chk("rst_val_a", 32'(ia.RndValidxSO), 32'd0);
    chk("rst_z_a", 32'(ia.RandomZ), 32'd0);
    chk("rst_b_a", 32'(ia.RandomB), 32'd0);
    chk("rst_rdy_b", 32'(ib.SeedReadyxSO), 32'd1);
    #10;
    rst_n = 1'b1;

    // ---------------- table: WARMUP_CYCLES = 0 instance ----------------
    // Idle in LOAD, with enable raised to show it has no effect.
    for (int i = 0; i < 4; i++) va.push_back(mk(0, 0, 32'h0, 1, 1, 0, 18'h0, 8'h0));
    // Lane 0 gets bit 30 set, other lanes get 1.
    va.push_back(mk(0, 1, 32'h4000_0000, 0, 1, 0, 18'h1, 8'h0));
    for (int k = 1; k < NL - 1; k++) va.push_back(mk(0, 1, 32'h0000_0001, 0, 1, 0, 18'h1, 8'h0));
    va.push_back(mk(0, 1, 32'h0000_0001, 0, 0, 1, 18'h1, 8'h0));
    // First enabled step: lane 0 -> 1, others -> 2.
    va.push_back(mk(0, 0, 32'h0, 1, 0, 1, 18'h0, 8'h0));
    // Enable low: bus frozen.
    for (int i = 0; i < 3; i++) va.push_back(mk(0, 0, 32'h0, 0, 0, 1, 18'h0, 8'h0));
    // 28 more steps with every MSB still clear.
    for (int i = 0; i < 28; i++) va.push_back(mk(0, 0, 32'h0, 1, 0, 1, 18'h0, 8'h0));
    // Lanes 1..25 reach bit 30, then lane 0 one step behind.
    va.push_back(mk(0, 0, 32'h0, 1, 0, 1, 18'h3FFFE, 8'hFF));
    va.push_back(mk(0, 0, 32'h0, 1, 0, 1, 18'h00001, 8'h00));
    // Reseed in RUN with enable high: no step, valid drops, ready rises.
    va.push_back(mk(1, 0, 32'h0, 1, 1, 0, 18'h00001, 8'h00));

    foreach (va[i]) begin
      ia.ReseedxSI    = va[i].rs;
      ia.SeedValidxSI = va[i].vld;
      ia.SeedxDI      = va[i].seed;
      ia.EnablexSI    = va[i].en;
      cyc();
      chk($sformatf("vec%0d_rdy", i), 32'(ia.SeedReadyxSO), 32'(va[i].rdy));
      chk($sformatf("vec%0d_val", i), 32'(ia.RndValidxSO), 32'(va[i].val));
      chk($sformatf("vec%0d_z", i), 32'(ia.RandomZ), 32'(va[i].z));
      chk($sformatf("vec%0d_b", i), 32'(ia.RandomB), 32'(va[i].b));
    end
    idle_a();

    // ---------------- reseed colliding with word 5 ----------------
    // Words 0..4 with bit 31 set (ignored) -> lanes 0..4 = 1, all MSBs clear.
    for (int k = 0; k < 5; k++) begin
      ia.SeedValidxSI = 1'b1;
      ia.SeedxDI      = 32'h8000_0001;
      cyc();
    end
    chk("part_z", 32'(ia.RandomZ), 32'h0);
    ia.ReseedxSI = 1'b1;
    ia.SeedxDI   = 32'h4000_0000;
    cyc();
    chk("rs_w5_z", 32'(ia.RandomZ), 32'h0);
    chk("rs_w5_rdy", 32'(ia.SeedReadyxSO), 32'd1);
    ia.ReseedxSI = 1'b0;
    cyc();
    // Counter restarted at 0: the word lands in lane 0, not lane 5.
    chk("rs_w0_z", 32'(ia.RandomZ), 32'h1);
    idle_a();
    ia.ReseedxSI = 1'b1;
    cyc();
    ia.ReseedxSI = 1'b0;

    // ---------------- zero seed, long model compare ----------------
    for (int k = 0; k < NL; k++) seeds_a[k] = 32'h9E37_79B9 * 32'(k + 1);
    seeds_a[3] = 32'h0000_0000;
    seeds_a[7] = 32'h8000_0000;
    for (int k = 0; k < NL; k++) begin
      ia.SeedValidxSI = 1'b1;
      ia.SeedxDI      = seeds_a[k];
      cyc();
      ma[k] = seed_of(seeds_a[k]);
    end
    idle_a();
    chk("a_run_val", 32'(ia.RndValidxSO), 32'd1);
    chk_model_a("a_seeded");
    for (int i = 0; i < 3000; i++) begin
      ia.EnablexSI = 1'($urandom_range(0, 1));
      cyc();
      if (ia.EnablexSI) begin
        for (int k = 0; k < NL; k++) ma[k] = lstep(ma[k]);
      end
      chk_model_a($sformatf("a_run%0d", i));
      if (ma[3] == 31'h0) chk("lane3_nonzero", 32'(ma[3]), 32'h1);
    end
    idle_a();

    // ---------------- WARMUP_CYCLES = 64 instance ----------------
    for (int k = 0; k < NL; k++) seeds_b[k] = 32'h0F1E_2D3C + 32'h1111_1111 * 32'(k);
    load_b();
    chk("b_wu_rdy", 32'(ib.SeedReadyxSO), 32'd0);
    chk("b_wu_val0", 32'(ib.RndValidxSO), 32'd0);
    for (int i = 1; i <= 64; i++) begin
      ib.EnablexSI = 1'(i % 2);
      cyc();
      for (int k = 0; k < NL; k++) mb[k] = lstep(mb[k]);
      chk($sformatf("b_wu%0d_val", i), 32'(ib.RndValidxSO), (i == 64) ? 32'd1 : 32'd0);
      chk_model_b($sformatf("b_wu%0d", i));
    end
    ib.EnablexSI = 1'b0;
    cyc();
    chk_model_b("b_hold");
    ib.EnablexSI = 1'b1;
    cyc();
    for (int k = 0; k < NL; k++) mb[k] = lstep(mb[k]);
    chk_model_b("b_step");
    ib.EnablexSI = 1'b1;
    ib.ReseedxSI = 1'b1;
    cyc();
    idle_b();
    chk("b_rs_val", 32'(ib.RndValidxSO), 32'd0);
    chk("b_rs_rdy", 32'(ib.SeedReadyxSO), 32'd1);
    chk_model_b("b_rs_keep");

    // ---------------- async reset mid-warm-up ----------------
    load_b();
    for (int i = 0; i < 10; i++) cyc();
    chk("b_mid_val", 32'(ib.RndValidxSO), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_rdy", 32'(ib.SeedReadyxSO), 32'd1);
    chk("arst_val", 32'(ib.RndValidxSO), 32'd0);
    chk("arst_z", 32'(ib.RandomZ), 32'd0);
    chk("arst_b", 32'(ib.RandomB), 32'd0);
    chk("arst_val_a", 32'(ia.RndValidxSO), 32'd0);
    cyc();
    cyc();
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) cyc();
    chk("post_rst_rdy", 32'(ib.SeedReadyxSO), 32'd1);
    chk("post_rst_val", 32'(ib.RndValidxSO), 32'd0);
    chk("post_rst_z", 32'(ib.RandomZ), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/aes_sbox_mask_prng.md
Name: aes_sbox_mask_prng

Overview:
- Fresh-mask generator sitting directly upstream of the masked, pipelined AES S-box.
- Produces the RandomZ and RandomB randomness buses every enabled cycle from an array of independent 31-bit LFSR lanes.
- Lanes are seeded word-by-word from an external TRNG/host over a valid/ready handshake.
- A warm-up phase runs before any output is declared valid.

Parameters:
- SHARES, 2: share count of the downstream S-box. Informational; sizes nothing here directly.
- Z_WIDTH, 18: RandomZ width. Equals coeff*SHARES*(SHARES-1) of the S-box (18 for SHARES=2).
- B_WIDTH, 8: RandomB width. Equals 2*4*blind_n_rnd of the S-box; the integrator sets it from blind.vh.
- WARMUP_CYCLES, 64: LFSR steps executed after seeding before output is valid. 0 is legal.

Ports:
- ClkxCI  in  1  clock, rising edge.
- RstxBI  in  1  reset, asynchronous, active-low.
- ReseedxSI  in  1  single-cycle request to restart seeding.
- SeedxDI  in  32  seed word. Bits [30:0] are used; bit 31 is ignored.
- SeedValidxSI  in  1  seed word valid.
- SeedReadyxSO  out  1  seed word accepted when SeedValidxSI and SeedReadyxSO are both high.
- EnablexSI  in  1  advance all lanes one step this cycle (used only in RUN).
- RandomZ  out  Z_WIDTH  multiplication masks for the S-box.
- RandomB  out  B_WIDTH  blinding randomness for the S-box.
- RndValidxSO  out  1  high while in RUN.

Behaviour:
- Lanes: L = Z_WIDTH + B_WIDTH independent 31-bit registers s_k, k = 0..L-1.
  - Step: s_k <= {s_k[29:0], s_k[30] ^ s_k[27]} (polynomial x^31 + x^28 + 1).
- Output mapping (direct from lane registers, no extra register, 0-cycle latency from lane state):
  - RandomZ[k] = s_k[30] for k < Z_WIDTH.
  - RandomB[j] = s_(Z_WIDTH+j)[30].
- Reset values:
  - All lanes = 31'h1, so RandomZ = 0 and RandomB = 0.
  - State = LOAD, word counter = 0, warm-up counter = 0.
  - SeedReadyxSO = 1 (it is combinational on state), RndValidxSO = 0.
- FSM LOAD:
  - SeedReadyxSO = 1, RndValidxSO = 0, lanes do not step.
  - On accept: lane[counter] <= SeedxDI[30:0], or 31'h1 if those bits are all zero (lock-up avoidance). Counter increments.
  - Accepting word L-1 moves to WARMUP, or to RUN if WARMUP_CYCLES = 0. The warm-up counter clears.
- FSM WARMUP:
  - SeedReadyxSO = 0, RndValidxSO = 0.
  - All lanes step every cycle, regardless of EnablexSI.
  - After exactly WARMUP_CYCLES steps, move to RUN.
- FSM RUN:
  - RndValidxSO = 1, SeedReadyxSO = 0.
  - Lanes step only in cycles with EnablexSI = 1; otherwise they hold and outputs are unchanged.
  - The S-box consumes the bus in the same cycle it is presented.
- Reseed:
  - ReseedxSI = 1 in any state moves to LOAD next cycle and clears the word counter. Lane contents are kept until overwritten.
  - RndValidxSO falls on the same edge.
  - ReseedxSI together with a seed accept in LOAD: reseed wins, the word is discarded, counter = 0.
  - ReseedxSI during WARMUP or RUN aborts immediately; no step occurs that cycle.
- Counter widths: clog2(L+1) for words, clog2(WARMUP_CYCLES+1) for warm-up. No wrap; counters stop at their terminal counts.
- Reset mid-operation: everything returns asynchronously to the reset values. A partially loaded seed is lost.
- EnablexSI in LOAD or WARMUP has no effect.

Test Plan:
- Reset release, no seed words: SeedReadyxSO = 1, RndValidxSO = 0, RandomZ = 0, RandomB = 0, held indefinitely.
- WARMUP_CYCLES = 0; lane 0 seeded 32'h4000_0000, other lanes seeded 32'h1:
  - After the last accept: RndValidxSO = 1, RandomZ[0] = 1.
  - One enabled cycle later: s_0 = 31'h1, RandomZ[0] = 0.
  - Further steps with EnablexSI = 0: bus frozen.
- All-zero seed word for lane 3 -> lane 3 loads 31'h1. Run 2^31-1 steps (or model compare over 10^5 steps): lane never reaches all-zero and matches a golden LFSR model.
- WARMUP_CYCLES = 64, full seed load:
  - RndValidxSO rises exactly 64 cycles after the final accept.
  - Lane states equal the golden model advanced 64 steps.
- ReseedxSI on the same cycle as word 5 accept in LOAD -> counter = 0, word 5 not written. Reseed pulse in RUN -> RndValidxSO = 0 next cycle, SeedReadyxSO = 1.
- Assert RstxBI low asynchronously mid-WARMUP -> outputs and state return to reset values without waiting for a clock edge.
